add_4: RTL and testbench



---
 rtl/add_4_if.sv | 41 ++++
 rtl/add_4.sv | 105 ++++++++++
 tb/tb_add_4.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/add_4_if.sv
// ============================================================================
//  Module      : add_4_if
//  Description : Operand / result bundle for the add_4 registered adder.
//                Master drives operands and consumes results; slave is the
//                adder stage. Optional signal ovf exists only when the macro
//                ADD_4_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface add_4_if;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       cout;
  logic [3:0] sum;
  logic       out_valid;
`ifdef ADD_4_OVF_EN
  logic       ovf;
`endif

  modport master (
    output in_valid, a, b, cin,
`ifdef ADD_4_OVF_EN
    input  ovf,
`endif
    input  cout, sum, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef ADD_4_OVF_EN
    output ovf,
`endif
    output cout, sum, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/add_4.sv
// ============================================================================
//  Module      : add_4
//  Description : Registered 4-bit adder, {cout,sum} = a + b + cin, on a
//                flattened carry-lookahead core. One-cycle latency, full
//                throughput, out_valid strobes once per captured operand set.
//                Define ADD_4_OVF_EN to add the registered signed-overflow
//                flag ovf (c[3] ^ c[4]).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module add_4 (
  input  wire logic clk,
  input  wire logic rst_n,
  add_4_if.slave    bus
);

  // Operands are forced to zero when not qualified so that X on idle inputs
  // never reaches the lookahead logic or the result registers.
  logic [3:0] w_a;
  logic [3:0] w_b;
  logic       w_cin;

  assign w_a   = bus.a   & {4{bus.in_valid}};
  assign w_b   = bus.b   & {4{bus.in_valid}};
  assign w_cin = bus.cin & bus.in_valid;

  // Per-bit generate / propagate terms.
  logic [3:0] w_g;
  logic [3:0] w_p;

  assign w_g = w_a & w_b;
  assign w_p = w_a ^ w_b;

  // Every carry is written out in full from g, p and cin: two logic levels,
  // no ripple path between bit positions.
  logic [4:0] w_c;

  assign w_c[0] = w_cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & w_cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & w_cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_cin);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cin);

  logic [3:0] w_sum;
  assign w_sum = w_p ^ w_c[3:0];

  // Result registers: capture on qualified edge, otherwise hold.
  logic [3:0] r_sum;
  logic       r_cout;
  logic       r_out_valid;

  // Load result on in_valid, hold otherwise; out_valid follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= 4'd0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_sum  <= w_sum;
        r_cout <= w_c[4];
      end
    end
  end

  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.out_valid = r_out_valid;

`ifdef ADD_4_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  logic r_ovf;

  // Overflow flag shares the capture rule of the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (bus.in_valid) begin
      r_ovf <= w_c[3] ^ w_c[4];
    end
  end

  assign bus.ovf = r_ovf;
`else
  // Top carry into the sign bit is only consumed by the overflow flag.
  logic w_unused_c3;
  assign w_unused_c3 = w_c[3];
`endif

endmodule

`default_nettype wire

// File: tb/tb_add_4.sv
// ============================================================================
//  Module      : tb_add_4
//  Description : Self-checking bench for add_4 with directed and random
//                operands against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_add_4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  add_4_if bus ();

  add_4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: last captured result.
  logic [4:0] exp_res = 5'd0;
  logic       exp_ovf = 1'b0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed range check for overflow.
  task automatic model(input logic [3:0] a, input logic [3:0] b, input logic ci);
    int u;
    int s;
    u = int'(a) + int'(b) + int'(ci);
    s = (a > 4'd7 ? int'(a) - 16 : int'(a)) + (b > 4'd7 ? int'(b) - 16 : int'(b)) + int'(ci);
    exp_res = u[4:0];
    exp_ovf = (s > 7) || (s < -8);
  endtask

  task automatic check_outs(input string tag, input logic vld);
    chk({tag, ".vld"}, {7'd0, bus.out_valid}, {7'd0, vld});
    chk({tag, ".res"}, {3'd0, bus.cout, bus.sum}, {3'd0, exp_res});
`ifdef ADD_4_OVF_EN
    chk({tag, ".ovf"}, {7'd0, bus.ovf}, {7'd0, exp_ovf});
`endif
  endtask

  task automatic cyc_in(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    model(a, b, ci);
    @(posedge clk);
    #1;
    check_outs(tag, 1'b1);
  endtask

  task automatic cyc_idle(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci);
    bus.in_valid = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.cin      = ci;
    @(posedge clk);
    #1;
    check_outs(tag, 1'b0);
  endtask

  logic [3:0] dir_a   [13] = '{0, 2, 4, 6, 8, 10, 12, 14, 15, 15, 7, 8, 3};
  logic [3:0] dir_b   [13] = '{1, 1, 5, 5, 9,  9, 13, 13, 15,  0, 1, 8, 2};
  logic       dir_cin [13] = '{0, 1, 0, 1, 0,  1,  0,  1,  1,  1, 0, 0, 0};

  initial begin
    bus.in_valid = 1'b1;
    bus.a        = 4'($urandom);
    bus.b        = 4'($urandom);
    bus.cin      = 1'($urandom);

    // Reset held with qualified random operands: outputs must stay zero.
    #1;
    check_outs("rst_async", 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.a   = 4'($urandom);
      bus.b   = 4'($urandom);
      bus.cin = 1'($urandom);
      @(posedge clk);
      #1;
      check_outs("rst_hold", 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc_in("post_rst", 4'd0, 4'd0, 1'b0);

    // Directed no-carry, carry-out, boundary and overflow cases.
    for (int i = 0; i < 13; i++) begin
      cyc_in($sformatf("dir%0d", i), dir_a[i], dir_b[i], dir_cin[i]);
    end

    // Back-to-back then idle hold with different operands.
    cyc_in("b2b0", 4'd1, 4'd2, 1'b0);
    cyc_in("b2b1", 4'd9, 4'd11, 1'b1);
    cyc_in("b2b2", 4'd5, 4'd6, 1'b0);
    cyc_idle("hold", 4'd3, 4'd3, 1'b0);
    cyc_idle("hold_x", 4'bxxxx, 4'bxxxx, 1'bx);
    cyc_in("after_x", 4'd4, 4'd3, 1'b1);

    // Asynchronous reset mid-stream clears a loaded result without a clock.
    cyc_in("pre_rst", 4'd15, 4'd15, 1'b1);
    #2;
    rst_n   = 1'b0;
    exp_res = 5'd0;
    exp_ovf = 1'b0;
    #1;
    check_outs("mid_rst", 1'b0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc_idle("rst_idle", 4'd7, 4'd7, 1'b1);
    cyc_in("rst_first", 4'd6, 4'd7, 1'b1);

    // Random mix of qualified and idle cycles.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) != 0)
        cyc_in("rnd", 4'($urandom), 4'($urandom), 1'($urandom));
      else
        cyc_idle("rnd_idle", 4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
